dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port (CPU / DMA) round-robin arbiter for banked data memory
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_rw,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_rw,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataIn,
  output logic        mem_readWrite,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_b_q, last_b_d;
  logic        grant_b_q, grant_b_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_rw_q, mem_rw_d;

  // Arbitration: B wins only if A is idle or A was served last.
  logic        any_req, pick_b, sel_rw, in_range;
  logic [31:0] sel_addr, sel_wdata;

  always_comb begin
    any_req   = a_req | b_req;
    pick_b    = b_req & (~a_req | ~last_b_q);
    sel_rw    = pick_b ? b_rw    : a_rw;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    in_range  = (sel_addr[31:13] == 19'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      last_b_q   <= 1'b1;
      grant_b_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= 32'd0;
      b_rdata_q  <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_data_q <= 32'd0;
      mem_rw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      grant_b_q  <= grant_b_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_rw_q   <= mem_rw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    grant_b_d = grant_b_q;
    rw_d      = rw_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_b_d = pick_b;
          last_b_d  = pick_b;
          rw_d      = sel_rw;
          state_d   = in_range ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (rw_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, so every port is a flop.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_rw_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req && in_range) begin
          mem_addr_d = {19'd0, sel_addr[12:0]};
          mem_data_d = sel_wdata;
          mem_rw_d   = sel_rw;
        end else if (any_req) begin
          if (pick_b) begin
            b_ack_d   = 1'b1;
            b_err_d   = 1'b1;
            b_rdata_d = 32'd0;
          end else begin
            a_ack_d   = 1'b1;
            a_err_d   = 1'b1;
            a_rdata_d = 32'd0;
          end
        end
      end
      S_ISSUE: begin
        if (rw_q) begin
          a_ack_d = ~grant_b_q;
          b_ack_d = grant_b_q;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          a_ack_d = ~grant_b_q;
          b_ack_d = grant_b_q;
          if (grant_b_q) begin
            b_rdata_d = mem_rdata;
          end else begin
            a_rdata_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign a_ack         = a_ack_q;
  assign b_ack         = b_ack_q;
  assign a_err         = a_err_q;
  assign b_err         = b_err_q;
  assign a_rdata       = a_rdata_q;
  assign b_rdata       = b_rdata_q;
  assign mem_addr      = mem_addr_q;
  assign mem_dataIn    = mem_data_q;
  assign mem_readWrite = mem_rw_q;
  assign busy          = busy_q;
  assign grant_b       = grant_b_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : scoreboard bench for dmem_arbiter with a latency-accurate memory model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int unsigned RD_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0, a_rw = 1'b0, b_req = 1'b0, b_rw = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_ack, a_err, b_ack, b_err, mem_readWrite, busy, grant_b;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_dataIn, mem_rdata;

  dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_readWrite(mem_readWrite),
    .mem_rdata(mem_rdata), .busy(busy), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears RD_LAT edges after the address is driven.
  logic [31:0] mem [0:8191];
  logic [12:0] pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (mem_readWrite) mem[mem_addr[12:0]] <= mem_dataIn;
    for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_addr[12:0];
  end
  assign mem_rdata = mem[pipe[RD_LAT-1]];

  typedef struct {
    logic        port_b;
    logic        rw;
    logic [31:0] addr;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic port_b, input logic rw, input logic [31:0] addr,
                      input logic err, input logic chk, input logic [31:0] rdata, input int lat);
    exp_t e;
    e.port_b = port_b; e.rw = rw; e.addr = addr; e.err = err;
    e.chk_rdata = chk; e.rdata = rdata; e.lat = lat;
    sb.push_back(e);
  endtask

  // Present one transaction on a port and hold it until that port's ack.
  task automatic drive(input logic port_b, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic last);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    if (port_b) begin
      b_req = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wdata;
    end
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = port_b ? b_ack : a_ack;
    end
    check(port_b ? "b_ack arrives" : "a_ack arrives", {31'd0, got}, 32'd1);
    if (last) begin
      if (port_b) b_req = 1'b0;
      else        a_req = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on every ack.
  initial begin
    int          cyc;
    int          start;
    int          wr_cnt;
    logic        busy_p;
    logic [31:0] pa, pb;
    exp_t        e;
    cyc = 0; start = 0; wr_cnt = 0; busy_p = 1'b0; pa = '0; pb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !busy_p) begin
        start  = cyc;
        wr_cnt = 0;
      end
      if (mem_readWrite) wr_cnt++;
      if (a_ack || b_ack) begin
        check("single ack", {31'd0, a_ack & b_ack}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected ack: a_ack=%0b b_ack=%0b, expected none", a_ack, b_ack);
        end else begin
          e = sb.pop_front();
          check("ack port", {31'd0, b_ack}, {31'd0, e.port_b});
          check("grant_b", {31'd0, grant_b}, {31'd0, e.port_b});
          check("latency", 32'(cyc - start + 1), 32'(e.lat));
          check("err", {31'd0, e.port_b ? b_err : a_err}, {31'd0, e.err});
          check("write strobes", 32'(wr_cnt), e.rw ? 32'd1 : 32'd0);
          if (e.chk_rdata) check("rdata", e.port_b ? b_rdata : a_rdata, e.rdata);
          if (!e.err) check("mem_addr", mem_addr, {19'd0, e.addr[12:0]});
          check("other port rdata held", e.port_b ? a_rdata : b_rdata, e.port_b ? pa : pb);
        end
      end
      busy_p = busy;
      pa     = a_rdata;
      pb     = b_rdata;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset grant_b", {31'd0, grant_b}, 32'd0);
    check("reset acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("reset errs", {30'd0, a_err, b_err}, 32'd0);
    check("reset a_rdata", a_rdata, 32'd0);
    check("reset b_rdata", b_rdata, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_dataIn", mem_dataIn, 32'd0);
    check("reset mem_readWrite", {31'd0, mem_readWrite}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // A write then A read of the same word
    push(1'b0, 1'b1, 32'h0000_0405, 1'b0, 1'b0, 32'h0, 2);
    drive(1'b0, 1'b1, 32'h0000_0405, 32'hDEAD_BEEF, 1'b1);
    push(1'b0, 1'b0, 32'h0000_0405, 1'b0, 1'b1, 32'hDEAD_BEEF, RD_LAT + 2);
    drive(1'b0, 1'b0, 32'h0000_0405, 32'h0, 1'b1);

    // B out-of-range read
    push(1'b1, 1'b0, 32'h0000_2000, 1'b1, 1'b1, 32'h0, 1);
    drive(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b1);

    // A write then B read of the same address
    push(1'b0, 1'b1, 32'h0000_1ABC, 1'b0, 1'b0, 32'h0, 2);
    drive(1'b0, 1'b1, 32'h0000_1ABC, 32'h1234_5678, 1'b1);
    push(1'b1, 1'b0, 32'h0000_1ABC, 1'b0, 1'b1, 32'h1234_5678, RD_LAT + 2);
    drive(1'b1, 1'b0, 32'h0000_1ABC, 32'h0, 1'b1);

    // Both ports contending for four transactions: A, B, A, B
    push(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 2);
    push(1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 32'h1111_1111, RD_LAT + 2);
    push(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 2);
    push(1'b1, 1'b0, 32'h0000_0020, 1'b0, 1'b1, 32'h2222_2222, RD_LAT + 2);
    fork
      begin
        drive(1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h2222_2222, 1'b1);
      end
      begin
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1);
      end
    join

    // Reset during WAIT of an A read; the held request is re-served afterwards
    push(1'b0, 1'b0, 32'h0000_0405, 1'b0, 1'b1, 32'hDEAD_BEEF, RD_LAT + 2);
    fork
      drive(1'b0, 1'b0, 32'h0000_0405, 32'h0, 1'b1);
      begin
        int n;
        n = 0;
        while (!busy && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("busy before abort", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort a_ack", {31'd0, a_ack}, 32'd0);
        check("abort a_rdata", a_rdata, 32'd0);
        reset = 1'b1;
      end
    join

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
